pipelined_addsub: RTL and testbench

- Parametrised successor to the team's fixed 16-bit ripple adder.
- WIDTH-bit adder/subtractor with the carry chain split into SEGMENTS equal slices; one pipeline register sits between slices.
- Valid/ready handshake on both sides, plus a full flag set: carry/borrow, signed overflow, zero, negative.
- Used as the ALU add path where the single-cycle 16-bit carry chain limits clock rate.

---
 rtl/pipelined_addsub_if.sv | 28 ++
 rtl/pipelined_addsub.sv | 132 +++++++++++++
 tb/tb_pipelined_addsub.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_addsub_if.sv
// Operand/result bundle for pipelined_addsub: valid/ready on both sides plus the result flags.
// The master drives operands and consumes results; the slave is the adder itself.
interface pipelined_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             ovfl;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, in1, in2, sub, out_ready,
        input  in_ready, out_valid, out, carry, ovfl, zero, neg
    );

    modport slave (
        input  in_valid, in1, in2, sub, out_ready,
        output in_ready, out_valid, out, carry, ovfl, zero, neg
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Purpose: WIDTH-bit add/sub, carry chain cut into SEGMENTS slices; ADDSUB_SATURATE_EN clamps on signed overflow.
// Latency: SEGMENTS cycles from accept to out_valid; one op per cycle.
// Backpressure: one global advance (!out_valid || out_ready) freezes every stage and drives in_ready.
module pipelined_addsub #(
    parameter int WIDTH    = 16,
    parameter int SEGMENTS = 4
) (
    input  logic               clk,
    input  logic               rst,
    pipelined_addsub_if.slave  bus
);
    localparam int S = WIDTH / SEGMENTS;
    localparam int L = SEGMENTS - 1;

    if ((WIDTH % SEGMENTS) != 0 || SEGMENTS < 1 || SEGMENTS > WIDTH) begin : g_bad_params
        $error("pipelined_addsub: WIDTH must be a multiple of SEGMENTS");
    end

    logic advance;

    // src_* is what stage k sees: the ports for stage 0, the stage k-1 register otherwise.
    logic             src_vld [SEGMENTS];
    logic [WIDTH-1:0] src_a   [SEGMENTS];
    logic [WIDTH-1:0] src_b   [SEGMENTS];
    logic [WIDTH-1:0] src_res [SEGMENTS];
    logic             src_c   [SEGMENTS];

    logic [WIDTH-1:0] nxt_res [SEGMENTS];
    logic             nxt_c   [SEGMENTS];

    logic             st_vld  [SEGMENTS];
    logic [WIDTH-1:0] st_a    [SEGMENTS];
    logic [WIDTH-1:0] st_b    [SEGMENTS];
    logic [WIDTH-1:0] st_res  [SEGMENTS];
    logic             st_c    [SEGMENTS];

    logic             out_vld_r;
    logic [WIDTH-1:0] out_r;
    logic             carry_r;
    logic             ovfl_r;
    logic             zero_r;
    logic             neg_r;

    logic             msb_cin;
    logic             fin_ovfl;
    logic [WIDTH-1:0] fin_out;

    assign advance = !out_vld_r || bus.out_ready;

    always_comb begin
        src_vld[0] = bus.in_valid;
        src_a[0]   = bus.in1;
        src_b[0]   = bus.sub ? ~bus.in2 : bus.in2;
        src_c[0]   = bus.sub;
        src_res[0] = '0;
        for (int k = 1; k < SEGMENTS; k++) begin
            src_vld[k] = st_vld[k-1];
            src_a[k]   = st_a[k-1];
            src_b[k]   = st_b[k-1];
            src_c[k]   = st_c[k-1];
            src_res[k] = st_res[k-1];
        end
    end

    always_comb begin
        logic [S:0] sl;
        for (int k = 0; k < SEGMENTS; k++) begin
            sl = {1'b0, src_a[k][k*S +: S]} + {1'b0, src_b[k][k*S +: S]} + {{S{1'b0}}, src_c[k]};
            nxt_res[k]          = src_res[k];
            nxt_res[k][k*S +: S] = sl[S-1:0];
            nxt_c[k]            = sl[S];
        end
    end

    // Carry into the MSB is recovered from the MSB sum bit, so no extra adder split is needed.
    assign msb_cin  = src_a[L][WIDTH-1] ^ src_b[L][WIDTH-1] ^ nxt_res[L][WIDTH-1];
    assign fin_ovfl = msb_cin ^ nxt_c[L];

`ifdef ADDSUB_SATURATE_EN
    always_comb begin
        fin_out = nxt_res[L];
        if (fin_ovfl) begin
            fin_out = src_a[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign fin_out = nxt_res[L];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SEGMENTS - 1; k++) begin
                st_vld[k] <= 1'b0;
                st_a[k]   <= '0;
                st_b[k]   <= '0;
                st_res[k] <= '0;
                st_c[k]   <= 1'b0;
            end
            out_vld_r <= 1'b0;
            out_r     <= '0;
            carry_r   <= 1'b0;
            ovfl_r    <= 1'b0;
            zero_r    <= 1'b0;
            neg_r     <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < SEGMENTS - 1; k++) begin
                st_vld[k] <= src_vld[k];
                st_a[k]   <= src_a[k];
                st_b[k]   <= src_b[k];
                st_res[k] <= nxt_res[k];
                st_c[k]   <= nxt_c[k];
            end
            out_vld_r <= src_vld[L];
            // Result and flags only change on a real op; bubbles leave the last values in place.
            if (src_vld[L]) begin
                out_r   <= fin_out;
                carry_r <= nxt_c[L];
                ovfl_r  <= fin_ovfl;
                zero_r  <= (fin_out == '0);
                neg_r   <= fin_out[WIDTH-1];
            end
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = out_vld_r;
    assign bus.out       = out_r;
    assign bus.carry     = carry_r;
    assign bus.ovfl      = ovfl_r;
    assign bus.zero      = zero_r;
    assign bus.neg       = neg_r;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub (WIDTH=16, SEGMENTS=4): scoreboard of expected results, directed steps.
module tb_pipelined_addsub;
    localparam int W = 16;

    logic clk;
    logic rst;

    pipelined_addsub_if #(.WIDTH(W)) bus ();

    pipelined_addsub #(.WIDTH(W), .SEGMENTS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] out;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t         q[$];
    exp_t         cur;
    int           checks   = 0;
    int           errors   = 0;
    int           cycle    = 0;
    bit           mon_en   = 0;
    bit           lat_mode = 0;
    bit           accepted = 0;
    bit           prev_stall = 0;
    logic [W-1:0] prev_out;
    logic [3:0]   prev_flags;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] o, input logic c, input logic v,
                                input logic z, input logic n);
        exp_t e;
        e.out = o; e.c = c; e.v = v; e.z = z; e.n = n; e.acc = 0; e.lat = 0;
        return e;
    endfunction

    // Independent reference: plain integer arithmetic over the whole word.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t        e;
        int          sa;
        int          sb;
        int          sr;
        logic [16:0] t;
        sa = int'($signed(a));
        sb = int'($signed(b));
        sr = s ? (sa - sb) : (sa + sb);
        t  = s ? ({1'b0, a} + 17'h10000 - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        e.c   = t[16];
        e.out = t[15:0];
        e.v   = (sr > 32767) || (sr < -32768);
`ifdef ADDSUB_SATURATE_EN
        if (e.v) e.out = (sa < 0) ? 16'h8000 : 16'h7fff;
`endif
        e.z   = (e.out == '0);
        e.n   = e.out[W-1];
        e.acc = 0;
        e.lat = 0;
        return e;
    endfunction

    // One clock: observe at the falling edge, then advance past the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        accepted = 0;
        if (mon_en && !rst) begin
            if (prev_stall) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_out", bus.out, prev_out);
                chk("hold_flags", {bus.carry, bus.ovfl, bus.zero, bus.neg}, prev_flags);
            end
            if (lat_mode && (q.size() == 0 || q[0].lat))
                chk("valid_timing", bus.out_valid, (q.size() > 0 && q[0].acc + 4 == cycle));
            if (bus.out_valid && !bus.out_ready)
                chk("in_ready_stall", bus.in_ready, 0);
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", bus.out_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("out", bus.out, e.out);
                    chk("carry", bus.carry, e.c);
                    chk("ovfl", bus.ovfl, e.v);
                    chk("zero", bus.zero, e.z);
                    chk("neg", bus.neg, e.n);
                    if (e.lat) chk("latency", cycle - e.acc, 4);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = bus.out;
            prev_flags = {bus.carry, bus.ovfl, bus.zero, bus.neg};
            if (bus.in_valid && bus.in_ready) begin
                e     = cur;
                e.acc = cycle;
                e.lat = lat_mode;
                q.push_back(e);
                accepted = 1;
            end
        end
        @(posedge clk);
        cycle++;
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input exp_t e);
        int n;
        bus.in_valid = 1'b1;
        bus.in1      = a;
        bus.in2      = b;
        bus.sub      = s;
        cur          = e;
        n            = 0;
        accepted     = 0;
        while (!accepted && n < 20) begin
            step();
            n++;
        end
        if (!accepted) chk("accept_timeout", bus.in_ready, 1);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int idx;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out", bus.out, 0);
        chk("rst_flags", {bus.carry, bus.ovfl, bus.zero, bus.neg}, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        rst    = 1'b0;
        mon_en = 1;

        // Directed corner cases, back to back with the consumer always ready.
        lat_mode = 1;
`ifdef ADDSUB_SATURATE_EN
        send(16'h7fff, 16'h0001, 1'b0, mk(16'h7fff, 1'b0, 1'b1, 1'b0, 1'b0));
`else
        send(16'h7fff, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1, 1'b0, 1'b1));
`endif
        send(16'hffff, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0));
        send(16'h00ff, 16'h0001, 1'b0, mk(16'h0100, 1'b0, 1'b0, 1'b0, 1'b0));
        send(16'h0fff, 16'h0001, 1'b0, mk(16'h1000, 1'b0, 1'b0, 1'b0, 1'b0));
        send(16'h0005, 16'h0007, 1'b1, mk(16'hfffe, 1'b0, 1'b0, 1'b0, 1'b1));
`ifdef ADDSUB_SATURATE_EN
        send(16'h8000, 16'h0001, 1'b1, mk(16'h8000, 1'b1, 1'b1, 1'b0, 1'b1));
        send(16'h8000, 16'h8000, 1'b0, mk(16'h8000, 1'b1, 1'b1, 1'b0, 1'b1));
`else
        send(16'h8000, 16'h0001, 1'b1, mk(16'h7fff, 1'b1, 1'b1, 1'b0, 1'b0));
        send(16'h8000, 16'h8000, 1'b0, mk(16'h0000, 1'b1, 1'b1, 1'b1, 1'b0));
`endif
        send(16'h0007, 16'h0005, 1'b1, mk(16'h0002, 1'b1, 1'b0, 1'b0, 1'b0));
        send(16'h1234, 16'h1234, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0));
        send(16'h1234, 16'h4321, 1'b0, mk(16'h5555, 1'b0, 1'b0, 1'b0, 1'b0));
        idle(6);
        chk("directed_drained", q.size(), 0);

        // Six back-to-back ops with the consumer stalled for three cycles mid-stream.
        lat_mode = 0;
        idx = 0;
        for (int i = 0; i < 40 && (idx < 6 || q.size() > 0); i++) begin
            bus.out_ready = !(i >= 5 && i < 8);
            if (idx < 6) begin
                ra = 16'h1111 * 16'(idx + 1);
                rb = 16'h0f0f + 16'(idx);
                rs = idx[0];
                bus.in_valid = 1'b1;
                bus.in1 = ra;
                bus.in2 = rb;
                bus.sub = rs;
                cur = model(ra, rb, rs);
            end else begin
                bus.in_valid = 1'b0;
            end
            step();
            if (accepted) idx++;
        end
        bus.out_ready = 1'b1;
        chk("stall_all_accepted", idx, 6);
        chk("stall_drained", q.size(), 0);
        idle(2);

        // Random operands with random bubbles, consumer always ready.
        lat_mode = 1;
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in1 = ra;
            bus.in2 = rb;
            bus.sub = rs;
            cur = model(ra, rb, rs);
            step();
        end
        idle(6);
        chk("random_drained", q.size(), 0);

        // Reset with three ops in flight: none of them may emerge.
        send(16'h0001, 16'h0002, 1'b0, model(16'h0001, 16'h0002, 1'b0));
        send(16'h00f0, 16'h0010, 1'b0, model(16'h00f0, 16'h0010, 1'b0));
        send(16'h4000, 16'h4000, 1'b0, model(16'h4000, 16'h4000, 1'b0));
        bus.in_valid = 1'b0;
        rst = 1'b1;
        q.delete();
        step();
        rst = 1'b0;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_out", bus.out, 0);
        chk("midrst_flags", {bus.carry, bus.ovfl, bus.zero, bus.neg}, 0);
        idle(5);
        send(16'h2222, 16'h1111, 1'b1, mk(16'h1111, 1'b1, 1'b0, 1'b0, 1'b0));
        idle(6);
        chk("final_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
